// File: rtl/penc_pkg.sv
// Shared types and helpers for the penc_serialiser priority encoder.
// Holds the drain FSM state encoding and the index-width function.
package penc_pkg;

    // Two-state controller: waiting for a vector, or emitting its indices.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Index width for an N-input encoder; never narrower than one bit.
    function automatic int penc_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/penc_msb_find.sv
// Combinational highest-set-bit finder for an N-bit vector.
// Returns the index, an any-bit-set flag and a one-hot mask of that bit.
module penc_msb_find
    import penc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = penc_w(N)
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any,
    output logic [N-1:0] o_mask
);

    // Upward scan: the last set bit seen is the highest, so it wins.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        o_mask = '0;
        for (int k = 0; k < N; k++) begin
            if (i_vec[k]) begin
                o_idx     = W'(k);
                o_any     = 1'b1;
                o_mask    = '0;
                o_mask[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/penc_serialiser.sv
// Captures a multi-hot request vector, then emits one index per beat, MSB first.
// Optional PENC_POPCNT_EN adds out_cnt, the popcount of the captured vector.
module penc_serialiser
    import penc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = penc_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_req,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         out_none
`ifdef PENC_POPCNT_EN
    ,
    output logic [W:0]   out_cnt
`endif
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_pend;
    logic [N-1:0]   w_pend_nxt;
    logic           r_nonzero;
    logic           w_nonzero_nxt;

    logic [W-1:0]   w_idx;
    logic           w_any;
    logic [N-1:0]   w_mask;
    logic           w_drain;
    logic           w_last;

    penc_msb_find #(
        .N      (N),
        .W      (W)
    ) u_msb (
        .i_vec  (r_pend),
        .o_idx  (w_idx),
        .o_any  (w_any),
        .o_mask (w_mask)
    );

    assign w_drain = (r_state == DRAIN);

    // Last beat once the reported bit is the only one left (or pend is empty).
    assign w_last = w_drain && ((r_pend & ~w_mask) == '0);

    // Outputs depend only on registered state and pend.
    always_comb begin
        in_ready  = !w_drain;
        out_valid = w_drain;
        out_idx   = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        if (w_drain) begin
            out_idx  = w_any ? w_idx : '0;
            out_last = w_last;
            out_none = !r_nonzero;
        end
    end

    // Next-state logic: capture in IDLE, peel one bit per accepted beat in DRAIN.
    always_comb begin
        w_state_nxt   = r_state;
        w_pend_nxt    = r_pend;
        w_nonzero_nxt = r_nonzero;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_pend_nxt    = in_req;
                    w_nonzero_nxt = |in_req;
                    w_state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    w_pend_nxt = r_pend & ~w_mask;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, pending vector and zero-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pend    <= '0;
            r_nonzero <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_nonzero <= w_nonzero_nxt;
        end
    end

`ifdef PENC_POPCNT_EN
    logic [W:0] r_cnt;
    logic [W:0] w_cnt;

    // Popcount of the incoming request vector.
    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < N; k++) begin
            w_cnt = w_cnt + (W+1)'(in_req[k]);
        end
    end

    // Count is latched at capture and held through the drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!w_drain && in_valid) begin
            r_cnt <= w_cnt;
        end
    end

    assign out_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_penc_serialiser.sv
// Self-checking bench for penc_serialiser (N=8 and N=4 instances).
// Expected beats come from a queue-based model of the set-bit list.
module tb_penc_serialiser;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] req8;
    logic       iv8, or8;
    logic       ir8, ov8, ol8, on8;
    logic [2:0] idx8;

    logic [3:0] req4;
    logic       iv4, or4;
    logic       ir4, ov4, ol4, on4;
    logic [1:0] idx4;

`ifdef PENC_POPCNT_EN
    logic [3:0] cnt8;
    logic [2:0] cnt4;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int exp_cnt;

    always #5 clk = ~clk;

    penc_serialiser #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (req8),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .out_idx   (idx8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_last  (ol8),
        .out_none  (on8)
`ifdef PENC_POPCNT_EN
        ,
        .out_cnt   (cnt8)
`endif
    );

    penc_serialiser #(.N(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (req4),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .out_idx   (idx4),
        .out_valid (ov4),
        .out_ready (or4),
        .out_last  (ol4),
        .out_none  (on4)
`ifdef PENC_POPCNT_EN
        ,
        .out_cnt   (cnt4)
`endif
    );

    // Model: list of set-bit indices, highest first; -1 marks the all-zero beat.
    function automatic void build_exp(input logic [7:0] v);
        exp_q.delete();
        for (int k = 7; k >= 0; k--)
            if (v[k]) exp_q.push_back(k);
        if (exp_q.size() == 0) exp_q.push_back(-1);
        exp_cnt = $countones(v);
    endfunction

    // Expected {valid, in_ready, idx, last, none} for the head beat.
    function automatic logic [6:0] exp_beat();
        int e;
        e = exp_q[0];
        return {1'b1, 1'b0, (e < 0) ? 3'd0 : 3'(e),
                exp_q.size() == 1, e < 0};
    endfunction

    task automatic cap8(input logic [7:0] v);
        req8 = v;
        iv8  = 1'b1;
        @(negedge clk);
        iv8  = 1'b0;
        req8 = 8'($urandom);
    endtask

    task automatic test_reset();
        vectors++;
        if ({ov8, ir8, idx8, ol8, on8} !== 7'b0100000) begin
            miscompares++;
            $display("FAIL reset8 got=%b exp=%b", {ov8, ir8, idx8, ol8, on8}, 7'b0100000);
        end
        vectors++;
        if ({ov4, ir4, idx4, ol4, on4} !== 6'b010000) begin
            miscompares++;
            $display("FAIL reset4 got=%b exp=%b", {ov4, ir4, idx4, ol4, on4}, 6'b010000);
        end
`ifdef PENC_POPCNT_EN
        vectors++;
        if (cnt8 !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got=%0d exp=0", cnt8);
        end
`endif
    endtask

    task automatic test_onehot4();
        or4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req4 = 4'(1 << k);
            iv4  = 1'b1;
            @(negedge clk);
            iv4  = 1'b0;
            vectors++;
            if ({ov4, idx4, ol4, on4} !== {1'b1, 2'(k), 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL onehot%0d got=%b exp=%b", k, {ov4, idx4, ol4, on4},
                         {1'b1, 2'(k), 1'b1, 1'b0});
            end
`ifdef PENC_POPCNT_EN
            vectors++;
            if (cnt4 !== 3'd1) begin
                miscompares++;
                $display("FAIL onehot_cnt got=%0d exp=1", cnt4);
            end
`endif
            @(negedge clk);
            vectors++;
            if ({ov4, ir4} !== 2'b01) begin
                miscompares++;
                $display("FAIL onehot_idle%0d got=%b exp=01", k, {ov4, ir4});
            end
        end
    endtask

    task automatic test_multi_hot();
        int cyc = 0;
        or8 = 1'b1;
        build_exp(8'b1001_0110);
        cap8(8'b1001_0110);
        while (exp_q.size() > 0 && cyc < 50) begin
            iv8 = 1'($urandom);
            vectors++;
            if ({ov8, ir8, idx8, ol8, on8} !== exp_beat()) begin
                miscompares++;
                $display("FAIL multi_hot got=%b exp=%b", {ov8, ir8, idx8, ol8, on8}, exp_beat());
            end
            @(negedge clk);
            cyc++;
            void'(exp_q.pop_front());
        end
        iv8 = 1'b0;
        vectors++;
        if ({ov8, ir8} !== 2'b01) begin
            miscompares++;
            $display("FAIL multi_hot_end got=%b exp=01", {ov8, ir8});
        end
    endtask

    task automatic test_all_zero();
        or8 = 1'b1;
        build_exp(8'h00);
        cap8(8'h00);
        vectors++;
        if ({ov8, ir8, idx8, ol8, on8} !== exp_beat()) begin
            miscompares++;
            $display("FAIL all_zero got=%b exp=%b", {ov8, ir8, idx8, ol8, on8}, exp_beat());
        end
`ifdef PENC_POPCNT_EN
        vectors++;
        if (cnt8 !== 4'd0) begin
            miscompares++;
            $display("FAIL all_zero_cnt got=%0d exp=0", cnt8);
        end
`endif
        @(negedge clk);
        vectors++;
        if ({ov8, ir8} !== 2'b01) begin
            miscompares++;
            $display("FAIL all_zero_end got=%b exp=01", {ov8, ir8});
        end
    endtask

    task automatic test_backpressure();
        int cyc   = 0;
        int beats = 0;
        build_exp(8'hFF);
        or8 = 1'b0;
        cap8(8'hFF);
        while (exp_q.size() > 0 && cyc < 60) begin
            or8 = (cyc >= 5);
            vectors++;
            if ({ov8, ir8, idx8, ol8, on8} !== exp_beat()) begin
                miscompares++;
                $display("FAIL backpressure c%0d got=%b exp=%b", cyc,
                         {ov8, ir8, idx8, ol8, on8}, exp_beat());
            end
`ifdef PENC_POPCNT_EN
            vectors++;
            if (cnt8 !== 4'd8) begin
                miscompares++;
                $display("FAIL backpressure_cnt got=%0d exp=8", cnt8);
            end
`endif
            @(negedge clk);
            cyc++;
            if (or8) begin
                void'(exp_q.pop_front());
                beats++;
            end
        end
        vectors++;
        if (beats != 8 || {ov8, ir8} !== 2'b01) begin
            miscompares++;
            $display("FAIL backpressure_end beats=%0d vr=%b exp 8/01", beats, {ov8, ir8});
        end
    endtask

    task automatic test_reset_mid();
        or8 = 1'b1;
        cap8(8'b1010_0000);
        vectors++;
        if ({ov8, idx8} !== {1'b1, 3'd7}) begin
            miscompares++;
            $display("FAIL mid_first got=%b exp=%b", {ov8, idx8}, {1'b1, 3'd7});
        end
        @(negedge clk);
        vectors++;
        if ({ov8, idx8} !== {1'b1, 3'd5}) begin
            miscompares++;
            $display("FAIL mid_second got=%b exp=%b", {ov8, idx8}, {1'b1, 3'd5});
        end
        or8   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ov8, ir8, idx8, ol8, on8} !== 7'b0100000) begin
            miscompares++;
            $display("FAIL mid_async got=%b exp=0100000", {ov8, ir8, idx8, ol8, on8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        or8   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({ov8, ir8} !== 2'b01) begin
                miscompares++;
                $display("FAIL mid_after%0d got=%b exp=01", c, {ov8, ir8});
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [7:0] v;
            int         cyc;
            cyc = 0;
            v   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            build_exp(v);
            cap8(v);
            while (exp_q.size() > 0 && cyc < 100) begin
                or8 = ($urandom_range(0, 3) != 0);
                iv8 = 1'($urandom);
                vectors++;
                if ({ov8, ir8, idx8, ol8, on8} !== exp_beat()) begin
                    miscompares++;
                    $display("FAIL random v=%h got=%b exp=%b", v,
                             {ov8, ir8, idx8, ol8, on8}, exp_beat());
                end
`ifdef PENC_POPCNT_EN
                vectors++;
                if (cnt8 !== 4'(exp_cnt)) begin
                    miscompares++;
                    $display("FAIL random_cnt got=%0d exp=%0d", cnt8, exp_cnt);
                end
`endif
                @(negedge clk);
                cyc++;
                if (or8) void'(exp_q.pop_front());
            end
            iv8 = 1'b0;
            vectors++;
            if (exp_q.size() != 0 || {ov8, ir8} !== 2'b01) begin
                miscompares++;
                $display("FAIL random_end v=%h left=%0d vr=%b exp 0/01", v,
                         exp_q.size(), {ov8, ir8});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req8  = '0;
        iv8   = 1'b0;
        or8   = 1'b0;
        req4  = '0;
        iv4   = 1'b0;
        or4   = 1'b0;
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_onehot4();
        test_multi_hot();
        test_all_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
